// File: rtl/vec_load_seq_if.sv
// vec_load_seq_if: groups the request, memory read and VRF write-back signals
// of the vector-load sequencer.
//   master : requester/environment side (drives start, load parameters, mem_q)
//   slave  : sequencer side (drives mem_addr/mem_read, vdata/vregw/vwrite,
//            busy, done)
interface vec_load_seq_if #(
  parameter int ADDR_W = 8,
  parameter int LANES  = 4
);
  logic                 start;
  logic [ADDR_W-1:0]    base_addr;
  logic [ADDR_W-1:0]    stride;
  logic [1:0]           vreg_sel;
  logic [ADDR_W-1:0]    mem_addr;
  logic                 mem_read;
  logic [7:0]           mem_q;
  logic [8*LANES-1:0]   vdata;
  logic [1:0]           vregw;
  logic                 vwrite;
  logic                 busy;
  logic                 done;

  modport master (
    output start, base_addr, stride, vreg_sel, mem_q,
    input  mem_addr, mem_read, vdata, vregw, vwrite, busy, done
  );

  modport slave (
    input  start, base_addr, stride, vreg_sel, mem_q,
    output mem_addr, mem_read, vdata, vregw, vwrite, busy, done
  );
endinterface

// File: rtl/vec_load_seq.sv
// vec_load_seq: vector-load read sequencer. On start (in IDLE) it reads four
// bytes at base, base+stride, base+2*stride, base+3*stride (mod 2^ADDR_W)
// from a synchronous byte memory, packs lane 0 into the top byte of vdata,
// and strobes vwrite/done for one cycle.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : vec_load_seq_if.slave (start/base_addr/stride/vreg_sel in,
//           mem_addr/mem_read out, mem_q in, vdata/vregw/vwrite/busy/done out)
//
// state | meaning
// IDLE  | waiting for start; latches base/stride/vreg_sel on accept
// RD0   | read lane 0 address
// RD1   | read lane 1, capture lane 0
// RD2   | read lane 2, capture lane 1
// RD3   | read lane 3, capture lane 2
// LAST  | no read, address held, capture lane 3
// WB    | vwrite/done pulse, vdata complete
module vec_load_seq #(
  parameter int ADDR_W = 8,
  parameter int LANES  = 4
) (
  input logic          clock,
  input logic          reset,
  vec_load_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_RD2,
    S_RD3,
    S_LAST,
    S_WB
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]  addr_cnt;
  logic [ADDR_W-1:0]  stride_q;
  logic [1:0]         vregw_q;
  logic [8*LANES-1:0] vdata_q;

  logic       accept;
  logic       advance;
  logic       cap_en;
  logic [1:0] cap_lane;
  logic       rd_en;
  logic       wb_en;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // accept is internal only; every output is decoded from state or a register.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    advance   = 1'b0;
    cap_en    = 1'b0;
    cap_lane  = 2'd0;
    rd_en     = 1'b0;
    wb_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = S_RD0;
        end
      end
      S_RD0: begin
        rd_en     = 1'b1;
        advance   = 1'b1;
        state_nxt = S_RD1;
      end
      S_RD1: begin
        rd_en     = 1'b1;
        advance   = 1'b1;
        cap_en    = 1'b1;
        cap_lane  = 2'd0;
        state_nxt = S_RD2;
      end
      S_RD2: begin
        rd_en     = 1'b1;
        advance   = 1'b1;
        cap_en    = 1'b1;
        cap_lane  = 2'd1;
        state_nxt = S_RD3;
      end
      S_RD3: begin
        // no advance: LAST keeps presenting the lane 3 address
        rd_en     = 1'b1;
        cap_en    = 1'b1;
        cap_lane  = 2'd2;
        state_nxt = S_LAST;
      end
      S_LAST: begin
        cap_en    = 1'b1;
        cap_lane  = 2'd3;
        state_nxt = S_WB;
      end
      S_WB: begin
        wb_en     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_cnt <= '0;
      stride_q <= '0;
      vregw_q  <= '0;
      vdata_q  <= '0;
    end else begin
      if (accept) begin
        addr_cnt <= bus.base_addr;
        stride_q <= bus.stride;
        vregw_q  <= bus.vreg_sel;
      end else if (advance) begin
        addr_cnt <= addr_cnt + stride_q;
      end
      // lane k lands in the byte that keeps lane 0 at the top of the word
      if (cap_en) begin
        for (int k = 0; k < LANES; k++) begin
          if (int'(cap_lane) == k) vdata_q[8*(LANES-1-k) +: 8] <= bus.mem_q;
        end
      end
    end
  end

  assign bus.mem_addr = addr_cnt;
  assign bus.mem_read = rd_en;
  assign bus.vdata    = vdata_q;
  assign bus.vregw    = vregw_q;
  assign bus.vwrite   = wb_en;
  assign bus.done     = wb_en;
  assign bus.busy     = (state != S_IDLE);

endmodule
